// File: rtl/mips_ctrl_pkg.sv
// Shared definitions for the multi-cycle MIPS control unit: opcodes, FSM states,
// datapath select encodings and the DECODE dispatch rule.
package mips_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  localparam logic [5:0] FUNCT_JR = 6'b001000;

  typedef enum logic [4:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_MEM_ADDR,
    S_MEM_RD,
    S_MEM_WB,
    S_MEM_WR,
    S_R_EXEC,
    S_R_WB,
    S_ORI_EXEC,
    S_ORI_WB,
    S_LUI_WB,
    S_BRANCH,
    S_JUMP,
    S_JAL,
    S_JR,
    S_ERROR
  } state_e;

  typedef enum logic [1:0] {
    ALU_ADD   = 2'b00,
    ALU_SUB   = 2'b01,
    ALU_FUNCT = 2'b10,
    ALU_OR    = 2'b11
  } alu_op_e;

  typedef enum logic [1:0] {
    PC_ALU    = 2'b00,
    PC_ALUOUT = 2'b01,
    PC_JUMP   = 2'b10,
    PC_RS     = 2'b11
  } pc_src_e;

  typedef enum logic [1:0] {
    SRCB_RT      = 2'b00,
    SRCB_FOUR    = 2'b01,
    SRCB_IMM     = 2'b10,
    SRCB_IMM_SH2 = 2'b11
  } alu_src_b_e;

  typedef struct packed {
    logic       mem_read;
    logic       mem_write;
    logic       iord;
    logic       ir_write;
    logic       pc_write;
    pc_src_e    pc_source;
    logic       alu_src_a;
    alu_src_b_e alu_src_b;
    alu_op_e    alu_op;
    logic       reg_dst;
    logic       reg_write;
    logic       mem_to_reg;
    logic       lui;
    logic       jal;
    logic       ori;
    logic       instr_done;
  } ctrl_t;

  // States that wait on the memory handshake and are guarded by the timeout.
  function automatic logic is_mem_state(state_e s);
    return s inside {S_FETCH, S_MEM_RD, S_MEM_WR};
  endfunction

  function automatic state_e dispatch(logic [5:0] op, logic [5:0] funct);
    case (op)
      OP_LW, OP_SW:     return S_MEM_ADDR;
      OP_RTYPE:         return (funct == FUNCT_JR) ? S_JR : S_R_EXEC;
      OP_ORI:           return S_ORI_EXEC;
      OP_LUI:           return S_LUI_WB;
      OP_BEQ, OP_BNE:   return S_BRANCH;
      OP_J:             return S_JUMP;
      OP_JAL:           return S_JAL;
      default:          return S_ERROR;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// Instruction/handshake inputs and datapath control outputs of the control unit.
// slave = control unit side, master = datapath/memory side.
interface multicycle_control_if #(
  parameter int CNT_W = 32
);
  logic             run;
  logic [5:0]       op;
  logic [5:0]       funct;
  logic             zero;
  logic             mem_ready;

  logic             MemRead;
  logic             MemWrite;
  logic             IorD;
  logic             IRWrite;
  logic             PCWrite;
  logic [1:0]       PCSource;
  logic             ALUSrcA;
  logic [1:0]       ALUSrcB;
  logic [1:0]       ALUop;
  logic             RegDst;
  logic             RegWrite;
  logic             MemtoReg;
  logic             Lui;
  logic             Jal;
  logic             Ori;
  logic             instr_done;
  logic [CNT_W-1:0] instr_count;
  logic             illegal_op;
  logic             bus_error;

  modport slave (
    input  run, op, funct, zero, mem_ready,
    output MemRead, MemWrite, IorD, IRWrite, PCWrite, PCSource, ALUSrcA, ALUSrcB,
           ALUop, RegDst, RegWrite, MemtoReg, Lui, Jal, Ori, instr_done,
           instr_count, illegal_op, bus_error
  );

  modport master (
    output run, op, funct, zero, mem_ready,
    input  MemRead, MemWrite, IorD, IRWrite, PCWrite, PCSource, ALUSrcA, ALUSrcB,
           ALUop, RegDst, RegWrite, MemtoReg, Lui, Jal, Ori, instr_done,
           instr_count, illegal_op, bus_error
  );
endinterface

// File: rtl/mem_wait_timer.sv
// Counts cycles spent waiting on mem_ready; flags expiry when the wait reaches
// MEM_TIMEOUT and the memory is still not ready. MEM_TIMEOUT = 0 disables expiry.
module mem_wait_timer #(
  parameter int MEM_TIMEOUT = 15,
  parameter int WAIT_W      = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [WAIT_W-1:0] LIMIT = WAIT_W'(MEM_TIMEOUT);

  logic [WAIT_W-1:0] count;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

  // A ready in the limit cycle itself arrives with enable low, so it wins.
  assign expired = (MEM_TIMEOUT != 0) && enable && (count == LIMIT);

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS control FSM: sequences lw/sw/ori/lui/beq/bne/R-type/j/jal/jr,
// waits on a timed memory handshake and counts retired instructions.
module multicycle_control
  import mips_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 32,
  parameter int WAIT_W      = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  multicycle_control_if.slave  bus
);

  state_e           state;
  ctrl_t            ctrl;
  logic [CNT_W-1:0] instr_count_q;
  logic             illegal_q;
  logic             bus_error_q;
  logic             in_mem;
  logic             wait_expired;

  assign in_mem = is_mem_state(state);

  mem_wait_timer #(
    .MEM_TIMEOUT (MEM_TIMEOUT),
    .WAIT_W      (WAIT_W)
  ) u_wait_timer (
    .clk     (clk),
    .reset   (reset),
    .clear   (!in_mem || bus.mem_ready),
    .enable  (in_mem && !bus.mem_ready),
    .expired (wait_expired)
  );

  // Outputs follow the registered state; only the memory-completion strobes
  // (IRWrite, PCWrite in FETCH, instr_done in MEM_WR) look at mem_ready.
  always_comb begin
    // NOTE: default everything first so no path through the case infers a latch.
    ctrl = '0;
    case (state)
      S_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.ir_write  = bus.mem_ready;
        ctrl.pc_write  = bus.mem_ready;
      end
      S_DECODE:   ctrl.alu_src_b = SRCB_IMM_SH2;
      S_MEM_ADDR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
      end
      S_MEM_RD: begin
        ctrl.mem_read = 1'b1;
        ctrl.iord     = 1'b1;
      end
      S_MEM_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      S_MEM_WR: begin
        ctrl.mem_write  = 1'b1;
        ctrl.iord       = 1'b1;
        ctrl.instr_done = bus.mem_ready;
      end
      S_R_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_op    = ALU_FUNCT;
      end
      S_R_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.reg_dst    = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      S_ORI_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALU_OR;
        ctrl.ori       = 1'b1;
      end
      S_ORI_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.ori        = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      S_LUI_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.lui        = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      S_BRANCH: begin
        ctrl.alu_src_a  = 1'b1;
        ctrl.alu_op     = ALU_SUB;
        ctrl.pc_source  = PC_ALUOUT;
        ctrl.pc_write   = ((bus.op == OP_BEQ) && bus.zero) ||
                          ((bus.op == OP_BNE) && !bus.zero);
        ctrl.instr_done = 1'b1;
      end
      S_JUMP: begin
        ctrl.pc_write   = 1'b1;
        ctrl.pc_source  = PC_JUMP;
        ctrl.instr_done = 1'b1;
      end
      S_JAL: begin
        ctrl.pc_write   = 1'b1;
        ctrl.pc_source  = PC_JUMP;
        ctrl.reg_write  = 1'b1;
        ctrl.jal        = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      S_JR: begin
        ctrl.pc_write   = 1'b1;
        ctrl.pc_source  = PC_RS;
        ctrl.instr_done = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= S_IDLE;
      instr_count_q <= '0;
      illegal_q     <= 1'b0;
      bus_error_q   <= 1'b0;
    end else if (ctrl.instr_done) begin
      // run is sampled only here and in IDLE, so dropping it never aborts.
      instr_count_q <= instr_count_q + 1'b1;
      state         <= bus.run ? S_FETCH : S_IDLE;
    end else if (wait_expired) begin
      state       <= S_ERROR;
      bus_error_q <= 1'b1;
    end else begin
      case (state)
        S_IDLE:     if (bus.run) state <= S_FETCH;
        S_FETCH:    if (bus.mem_ready) state <= S_DECODE;
        S_DECODE: begin
          state <= dispatch(bus.op, bus.funct);
          if (dispatch(bus.op, bus.funct) == S_ERROR) illegal_q <= 1'b1;
        end
        S_MEM_ADDR: state <= (bus.op == OP_LW) ? S_MEM_RD : S_MEM_WR;
        S_MEM_RD:   if (bus.mem_ready) state <= S_MEM_WB;
        S_R_EXEC:   state <= S_R_WB;
        S_ORI_EXEC: state <= S_ORI_WB;
        default:    ;
      endcase
    end
  end

  assign bus.MemRead     = ctrl.mem_read;
  assign bus.MemWrite    = ctrl.mem_write;
  assign bus.IorD        = ctrl.iord;
  assign bus.IRWrite     = ctrl.ir_write;
  assign bus.PCWrite     = ctrl.pc_write;
  assign bus.PCSource    = ctrl.pc_source;
  assign bus.ALUSrcA     = ctrl.alu_src_a;
  assign bus.ALUSrcB     = ctrl.alu_src_b;
  assign bus.ALUop       = ctrl.alu_op;
  assign bus.RegDst      = ctrl.reg_dst;
  assign bus.RegWrite    = ctrl.reg_write;
  assign bus.MemtoReg    = ctrl.mem_to_reg;
  assign bus.Lui         = ctrl.lui;
  assign bus.Jal         = ctrl.jal;
  assign bus.Ori         = ctrl.ori;
  assign bus.instr_done  = ctrl.instr_done;
  assign bus.instr_count = instr_count_q;
  assign bus.illegal_op  = illegal_q;
  assign bus.bus_error   = bus_error_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: directed scenarios plus random
// instruction streams scored by per-instruction latency and strobe counts.
module tb_multicycle_control;

  localparam logic [5:0] LW = 6'h23, SW = 6'h2b, ORI = 6'h0d, LUI = 6'h0f;
  localparam logic [5:0] BEQ = 6'h04, BNE = 6'h05, J = 6'h02, JAL = 6'h03;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  multicycle_control_if #(.CNT_W(32)) bus ();

  multicycle_control #(
    .MEM_TIMEOUT (15),
    .CNT_W       (32),
    .WAIT_W      (8)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  logic [18:0] ctrl_vec;
  assign ctrl_vec = {bus.MemRead, bus.MemWrite, bus.IorD, bus.IRWrite, bus.PCWrite,
                     bus.PCSource, bus.ALUSrcA, bus.ALUSrcB, bus.ALUop, bus.RegDst,
                     bus.RegWrite, bus.MemtoReg, bus.Lui, bus.Jal, bus.Ori, bus.instr_done};

  int          passed = 0;
  int          total  = 0;
  logic [31:0] model_count;
  bit          in_idle;
  logic        last_pcw, last_rw, last_jal, last_regdst, last_m2r;
  logic [1:0]  last_pcsrc;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Entry: just after a rising edge, DUT in IDLE (in_idle) or FETCH.
  // Memory answers each request after the given number of not-ready cycles.
  task automatic run_instr(input logic [5:0] o, input logic [5:0] f, input logic z,
                           input int fw, input int dw, input bit keep_run);
    int cycles, irw, pcw, rw, mrd, mwr, m2r, access, req_cnt, base;
    bit done, is_lw, is_sw, is_r, is_jr;
    int exp_cycles, exp_pcw, exp_rw, exp_mrd;
    cycles = 0; irw = 0; pcw = 0; rw = 0; mrd = 0; mwr = 0; m2r = 0;
    access = 0; req_cnt = 0; done = 0;
    bus.op = o; bus.funct = f; bus.zero = z; bus.run = 1'b1;
    if (in_idle) begin
      @(negedge clk);
      check("idle_quiet", 64'(ctrl_vec), 64'(0));
      @(posedge clk); #1;
    end
    while (!done && cycles < 64) begin
      if (cycles == 1 && !keep_run) bus.run = 1'b0;
      if (bus.MemRead || bus.MemWrite) begin
        bus.mem_ready = (req_cnt == ((access == 0) ? fw : dw));
        if (bus.mem_ready) begin req_cnt = 0; access++; end
        else req_cnt++;
      end else begin
        bus.mem_ready = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
      cycles++;
      if (bus.IRWrite)  irw++;
      if (bus.PCWrite)  pcw++;
      if (bus.RegWrite) rw++;
      if (bus.MemRead)  mrd++;
      if (bus.MemWrite) mwr++;
      if (bus.MemtoReg) m2r++;
      if (bus.instr_done) begin
        done = 1;
        last_pcw = bus.PCWrite; last_rw = bus.RegWrite; last_jal = bus.Jal;
        last_regdst = bus.RegDst; last_m2r = bus.MemtoReg; last_pcsrc = bus.PCSource;
      end
      @(posedge clk); #1;
    end
    is_lw = (o == LW); is_sw = (o == SW);
    is_r  = (o == 6'h00) && (f != 6'h08);
    is_jr = (o == 6'h00) && (f == 6'h08);
    base  = is_lw ? 5 : (is_sw || is_r || o == ORI) ? 4 : 3;
    exp_cycles = base + fw + ((is_lw || is_sw) ? dw : 0);
    exp_pcw = 1 + ((o == J || o == JAL || is_jr) ? 1 : 0)
                + ((o == BEQ && z) ? 1 : 0) + ((o == BNE && !z) ? 1 : 0);
    exp_rw  = (is_lw || is_r || o == ORI || o == LUI || o == JAL) ? 1 : 0;
    exp_mrd = 1 + fw + (is_lw ? 1 + dw : 0);
    model_count = model_count + 1;
    check("retired",     64'(done),   64'(1));
    check("latency",     64'(cycles), 64'(exp_cycles));
    check("irwrite_cnt", 64'(irw),    64'(1));
    check("pcwrite_cnt", 64'(pcw),    64'(exp_pcw));
    check("regwrite_cnt",64'(rw),     64'(exp_rw));
    check("memread_cnt", 64'(mrd),    64'(exp_mrd));
    check("memwrite_cnt",64'(mwr),    64'(is_sw ? 1 + dw : 0));
    check("memtoreg_cnt",64'(m2r),    64'(is_lw ? 1 : 0));
    check("instr_count", 64'(bus.instr_count), 64'(model_count));
    in_idle = !keep_run;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    logic [5:0] rfuncts [5];
    logic [5:0] o, f;
    int k, nz, cyc, mw;
    bit seen;
    logic [18:0] err_vec;
    rfuncts = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2a};
    model_count = 0;
    in_idle = 1;
    reset = 1'b1;
    bus.run = 1'b0; bus.op = '0; bus.funct = '0; bus.zero = 1'b0; bus.mem_ready = 1'b0;

    #12;
    check("rst_outputs",     64'(ctrl_vec),        64'(0));
    check("rst_count",       64'(bus.instr_count), 64'(0));
    check("rst_illegal",     64'(bus.illegal_op),  64'(0));
    check("rst_bus_error",   64'(bus.bus_error),   64'(0));
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    check("idle_holds", 64'(ctrl_vec), 64'(0));
    @(posedge clk); #1;

    // R-type add, zero wait states.
    run_instr(6'h00, 6'h20, 1'b0, 0, 0, 1);
    check("r_wb_regwrite", 64'(last_rw),     64'(1));
    check("r_wb_regdst",   64'(last_regdst), 64'(1));

    // lw with 3 fetch waits and 2 data waits -> 10 cycles.
    run_instr(LW, 6'h00, 1'b0, 3, 2, 1);
    check("lw_memtoreg_last", 64'(last_m2r), 64'(1));

    run_instr(BEQ, 6'h00, 1'b1, 0, 0, 1);
    check("beq_taken",     64'(last_pcw), 64'(1));
    run_instr(BEQ, 6'h00, 1'b0, 0, 0, 1);
    check("beq_not_taken", 64'(last_pcw), 64'(0));
    run_instr(BNE, 6'h00, 1'b0, 0, 0, 1);
    check("bne_taken",     64'(last_pcw), 64'(1));

    run_instr(JAL, 6'h00, 1'b0, 0, 0, 1);
    check("jal_pcwrite",  64'(last_pcw),   64'(1));
    check("jal_regwrite", 64'(last_rw),    64'(1));
    check("jal_flag",     64'(last_jal),   64'(1));
    check("jal_pcsource", 64'(last_pcsrc), 64'(2));
    run_instr(6'h00, 6'h08, 1'b0, 0, 0, 1);
    check("jr_pcsource",  64'(last_pcsrc), 64'(3));
    check("jr_regwrite",  64'(last_rw),    64'(0));

    run_instr(ORI, 6'h11, 1'b0, 0, 0, 1);
    run_instr(LUI, 6'h00, 1'b0, 1, 0, 1);
    run_instr(SW,  6'h00, 1'b0, 0, 0, 0);

    for (int n = 0; n < 40; n++) begin
      k = int'($urandom_range(0, 9));
      f = 6'($urandom);
      case (k)
        0: o = LW;
        1: o = SW;
        2: begin o = 6'h00; f = rfuncts[$urandom_range(0, 4)]; end
        3: o = ORI;
        4: o = LUI;
        5: o = BEQ;
        6: o = BNE;
        7: o = J;
        8: o = JAL;
        default: begin o = 6'h00; f = 6'h08; end
      endcase
      run_instr(o, f, 1'($urandom_range(0, 1)), int'($urandom_range(0, 4)),
                int'($urandom_range(0, 4)), ($urandom_range(0, 3) != 0));
    end

    // Illegal opcode: ERROR holds with all controls low.
    bus.op = 6'h3f; bus.run = 1'b1;
    if (in_idle) begin @(posedge clk); #1; end
    bus.mem_ready = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    check("illegal_flag", 64'(bus.illegal_op), 64'(1));
    nz = 0;
    repeat (20) begin
      bus.mem_ready = 1'($urandom_range(0, 1));
      bus.zero = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (ctrl_vec != '0) nz++;
      @(posedge clk); #1;
    end
    check("error_quiet_cycles", 64'(nz),              64'(0));
    check("error_count_held",   64'(bus.instr_count), 64'(model_count));
    check("illegal_sticky",     64'(bus.illegal_op),  64'(1));
    #2 reset = 1'b1;
    #1;
    check("async_rst_illegal", 64'(bus.illegal_op),  64'(0));
    check("async_rst_count",   64'(bus.instr_count), 64'(0));
    check("async_rst_outputs", 64'(ctrl_vec),        64'(0));
    bus.run = 1'b0;
    @(negedge clk); reset = 1'b0;
    model_count = 0; in_idle = 1;
    @(posedge clk); #1;

    // sw never answered: 15 waited cycles tolerated, 16th not-ready cycle faults.
    bus.op = SW; bus.run = 1'b1;
    @(posedge clk); #1;
    cyc = 0; mw = 0; seen = 0; err_vec = '1;
    for (int c = 0; c < 40 && !seen; c++) begin
      bus.mem_ready = bus.MemRead;
      @(negedge clk);
      cyc++;
      if (bus.MemWrite) mw++;
      if (bus.bus_error) begin seen = 1; err_vec = ctrl_vec; end
      @(posedge clk); #1;
    end
    check("timeout_bus_error", 64'(seen),            64'(1));
    check("timeout_cycles",    64'(cyc),             64'(20));
    check("timeout_mw_cycles", 64'(mw),              64'(16));
    check("timeout_quiet",     64'(err_vec),         64'(0));
    check("timeout_no_retire", 64'(bus.instr_count), 64'(0));
    reset = 1'b1; bus.run = 1'b0;
    #1;
    check("rst_clears_bus_error", 64'(bus.bus_error), 64'(0));
    reset = 1'b0;
    in_idle = 1;
    @(posedge clk); #1;
    // Ready arriving in the limit cycle completes the store.
    run_instr(SW, 6'h00, 1'b0, 0, 15, 1);
    check("limit_ready_no_error", 64'(bus.bus_error), 64'(0));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Multi-cycle MIPS control unit: the FSM successor to the single-cycle decoder.
- Covers the same subset: lw, sw, ori, lui, beq, bne, R-type, j, jal, jr.
- Sequences each instruction over 3–5 states and drives datapath enables.
- Waits on a variable-latency memory handshake with timeout, flags illegal opcodes, and counts retired instructions.

Parameters:
MEM_TIMEOUT, 15, max cycles any memory state waits for mem_ready before fault; 0 disables timeout
CNT_W, 32, width of retired-instruction counter
WAIT_W, 8, width of memory wait counter; MEM_TIMEOUT must be < 2^WAIT_W

Ports:
clk  in  1  system clock
reset  in  1  asynchronous active-high reset
run  in  1  leave IDLE and begin fetching
op  in  6  IR[31:26], valid from DECODE onward
funct  in  6  IR[5:0]
zero  in  1  ALU zero flag
mem_ready  in  1  memory access complete this cycle
MemRead  out  1  memory read request
MemWrite  out  1  memory write request
IorD  out  1  0=PC address, 1=ALUOut address
IRWrite  out  1  load instruction register
PCWrite  out  1  unconditional PC load
PCSource  out  2  00 ALU, 01 ALUOut, 10 jump target, 11 rs (jr)
ALUSrcA  out  1  0=PC, 1=rs
ALUSrcB  out  2  00 rt, 01 const 4, 10 sign-ext imm, 11 imm<<2
ALUop  out  2  00 add, 01 sub, 10 funct, 11 or
RegDst  out  1  write rd (R-type)
RegWrite  out  1  register file write enable
MemtoReg  out  1  write data from MDR
Lui  out  1  write imm<<16
Jal  out  1  write PC to $31
Ori  out  1  zero-extend immediate
instr_done  out  1  one-cycle pulse on final state of each instruction
instr_count  out  CNT_W  retired instructions, wraps
illegal_op  out  1  sticky: unsupported opcode
bus_error  out  1  sticky: memory timeout

Behaviour:
- Reset is asynchronous and active-high.
- Reset state and values: state=IDLE, counters=0, sticky flags=0. All outputs decode to 0 in IDLE.
- Outputs are Moore, decoded from the registered state only.
  - Exception: IRWrite, PCWrite, instr_done in wait states also qualify with mem_ready (see below).
- IDLE: all outputs 0. Moves to FETCH when run=1, else stays.
- FETCH:
  - Drives MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUop=00, PCSource=00.
  - Holds until mem_ready. In the mem_ready cycle: IRWrite=1, PCWrite=1, next state=DECODE.
- DECODE:
  - Drives ALUSrcA=0, ALUSrcB=11, ALUop=00 (branch target into ALUOut).
  - Dispatch on op:
    - 100011 / 101011 -> MEM_ADDR
    - 000000 with funct=001000 -> JR; other funct -> R_EXEC
    - 001101 -> ORI_EXEC
    - 001111 -> LUI_WB
    - 000100 / 000101 -> BRANCH
    - 000010 -> JUMP
    - 000011 -> JAL
    - any other op -> ERROR with illegal_op set.
- MEM_ADDR: ALUSrcA=1, ALUSrcB=10, ALUop=00. Goes to MEM_RD (lw) or MEM_WR (sw).
- MEM_RD: MemRead=1, IorD=1. Waits for mem_ready, then MEM_WB.
- MEM_WB: RegWrite=1, MemtoReg=1, RegDst=0. Retire.
- MEM_WR: MemWrite=1, IorD=1. Waits for mem_ready and retires in that cycle.
- R_EXEC: ALUSrcA=1, ALUSrcB=00, ALUop=10. Then R_WB.
- R_WB: RegWrite=1, RegDst=1. Retire.
- ORI_EXEC: ALUSrcA=1, ALUSrcB=10, ALUop=11, Ori=1. Then ORI_WB.
- ORI_WB: RegWrite=1, Ori=1. Retire.
- LUI_WB: RegWrite=1, Lui=1. Retire.
- BRANCH:
  - ALUSrcA=1, ALUSrcB=00, ALUop=01, PCSource=01.
  - PCWrite = (op=beq & zero) | (op=bne & ~zero). Retire.
- JUMP: PCWrite=1, PCSource=10. Retire.
- JAL: PCWrite=1, PCSource=10, RegWrite=1, Jal=1. Retire.
- JR: PCWrite=1, PCSource=11. Retire.
- Retire semantics:
  - instr_done=1 for one cycle and instr_count+1 (wraps at 2^CNT_W).
  - Next state = FETCH if run=1, else IDLE.
- Latency with zero wait states:
  - 3 cycles: lui, beq/bne, j, jal, jr
  - 4 cycles: R-type, ori, sw
  - 5 cycles: lw
  - Each cycle mem_ready is low in a memory state adds one cycle.
- Wait counter:
  - Clears on entry to every memory state and increments each cycle mem_ready=0.
  - If MEM_TIMEOUT≠0 and the count reaches MEM_TIMEOUT with mem_ready still 0 -> ERROR, bus_error=1.
  - mem_ready=1 in that same cycle wins: no error.
- ERROR: all control outputs 0 and the state is held. Only reset exits it.
- Reset mid-instruction aborts immediately: no partial writes, counter cleared.
- run deasserting mid-instruction does not abort; it is sampled only at retire and in IDLE.

Decomposition:
- Shared package mips_ctrl_pkg holds:
  - opcode and funct constants
  - state enumeration
  - ALUop encodings (ADD/SUB/FUNCT/OR)
  - PCSource and ALUSrcB encodings.
- One sub-module, mem_wait_timer (WAIT_W counter plus timeout compare, clear/enable/expired), instantiated once.

Test Plan:
- Reset then run=1, op=000000, funct=100000, mem_ready always 1 -> states IDLE, FETCH, DECODE, R_EXEC, R_WB; RegWrite=RegDst=1 in R_WB; instr_count=1.
- lw (op=100011) with mem_ready low 3 cycles in FETCH and 2 in MEM_RD -> 10 cycles total; MemtoReg=RegWrite=1 in MEM_WB only; IRWrite exactly once.
- beq with zero=1, then beq with zero=0, then bne with zero=0 -> PCWrite pulses 1, 0, 1 in BRANCH; each instruction takes 3 cycles.
- jal, then jr (op=0, funct=001000) -> jal: PCWrite=RegWrite=Jal=1, PCSource=10; jr: PCSource=11, RegWrite=0.
- op=111111 -> ERROR, illegal_op=1, all outputs 0 for 20 cycles; async reset mid-cycle clears to IDLE.
- MEM_TIMEOUT=15, mem_ready held 0 in MEM_WR -> bus_error asserts when the wait count reaches 15; a repeat run with mem_ready=1 in that same cycle -> retires, no error.
